change_dispenser: RTL and testbench

Downstream stage of the vending machine controller: accepts a change amount and drives the coin-hopper mechanism to pay it out as a sequence of 10-unit and 5-unit coins. Each coin is a request/acknowledge handshake with the hopper, separated by a fixed gap. The block also tracks per-tube coin inventory and reports any amount it could not pay.

---
 rtl/change_pkg.sv | 17 +
 rtl/change_dispenser_tube.sv | 34 +++
 rtl/change_dispenser.sv | 184 ++++++++++++++++++
 tb/tb_change_dispenser.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/change_pkg.sv
// Shared types and constants for the change dispenser: FSM state encoding,
// coin values and the default amount width.
package change_pkg;

  localparam int AMT_W   = 8;
  localparam int COIN_5  = 5;
  localparam int COIN_10 = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_GAP,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/change_dispenser_tube.sv
// coin_tube_counter: saturating up/down coin count for one hopper tube,
// with an empty flag. Simultaneous inc and dec leave the count unchanged.
module coin_tube_counter #(
  parameter int TUBE_DEPTH = 31,
  parameter int INIT_COUNT = 16,
  localparam int CNT_W     = $clog2(TUBE_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TUBE_DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_COUNT);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= CNT_INIT;
    end else if (i_inc && !i_dec) begin
      if (r_count != CNT_MAX) r_count <= r_count + 1'b1;
    end else if (i_dec && !i_inc) begin
      if (r_count != '0) r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays a change amount as 10- and 5-unit coins through a
// request/ack hopper handshake. Tube inventory is built with CHANGE_INVENTORY_EN.
module change_dispenser #(
  parameter int AMT_W       = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 255,
  parameter int TUBE_DEPTH  = 31,
  parameter int INIT_COUNT  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             change_valid,
  input  logic [AMT_W-1:0] change_amt,
  input  logic             eject_ack,
  input  logic             refill_5,
  input  logic             refill_10,
  output logic             ready,
  output logic             eject_5,
  output logic             eject_10,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remainder,
  output logic             fault
);

  import change_pkg::*;

  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

  localparam logic [AMT_W-1:0]  C5        = AMT_W'(COIN_5);
  localparam logic [AMT_W-1:0]  C10       = AMT_W'(COIN_10);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  state_t            r_state;
  state_t            w_next;
  logic [AMT_W-1:0]  r_rem;
  logic              r_sel10;
  logic              r_eject_5;
  logic              r_eject_10;
  logic [WAIT_W-1:0] r_wait;
  logic [GAP_W-1:0]  r_gap;
  logic              r_done;
  logic              r_short;
  logic [AMT_W-1:0]  r_remainder;
  logic              r_fault;

  logic w_req;
  logic w_accept;
  logic w_ack;
  logic w_timeout;
  logic w_gap_end;
  logic w_has5;
  logic w_has10;
  logic w_pick10;
  logic w_pick5;

  assign w_req     = r_eject_5 | r_eject_10;
  assign ready     = (r_state == ST_IDLE) && !r_done;
  assign w_accept  = ready && change_valid;
  assign w_ack     = (r_state == ST_EJECT) && w_req && eject_ack;
  assign w_timeout = (r_state == ST_EJECT) && w_req && !eject_ack && (r_wait == WAIT_LAST);
  assign w_gap_end = (r_state == ST_GAP) && (r_gap == GAP_LAST);
  assign w_pick10  = (r_rem >= C10) && w_has10;
  assign w_pick5   = !w_pick10 && (r_rem >= C5) && w_has5;

`ifdef CHANGE_INVENTORY_EN
  localparam int CNT_W = $clog2(TUBE_DEPTH + 1);

  logic [CNT_W-1:0] w_cnt5;
  logic [CNT_W-1:0] w_cnt10;
  logic             w_empty5;
  logic             w_empty10;
  logic             w_unused_cnt;

  coin_tube_counter #(
    .TUBE_DEPTH (TUBE_DEPTH),
    .INIT_COUNT (INIT_COUNT)
  ) u_tube5 (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (refill_5),
    .i_dec   (w_ack && r_eject_5),
    .o_count (w_cnt5),
    .o_empty (w_empty5)
  );

  coin_tube_counter #(
    .TUBE_DEPTH (TUBE_DEPTH),
    .INIT_COUNT (INIT_COUNT)
  ) u_tube10 (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (refill_10),
    .i_dec   (w_ack && r_eject_10),
    .o_count (w_cnt10),
    .o_empty (w_empty10)
  );

  assign w_has5       = !w_empty5;
  assign w_has10      = !w_empty10;
  assign w_unused_cnt = ^{w_cnt5, w_cnt10};
`else
  logic w_unused_refill;

  assign w_has5          = 1'b1;
  assign w_has10         = 1'b1;
  assign w_unused_refill = refill_5 ^ refill_10;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = ST_SELECT;
      ST_SELECT: w_next = (w_pick10 || w_pick5) ? ST_EJECT : ST_FINISH;
      ST_EJECT: begin
        if (w_ack)          w_next = ST_GAP;
        else if (w_timeout) w_next = ST_FINISH;
      end
      ST_GAP:    if (w_gap_end) w_next = ST_SELECT;
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Request is raised on the first EJECT edge and held until ack or timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel10     <= 1'b0;
      r_eject_5   <= 1'b0;
      r_eject_10  <= 1'b0;
      r_wait      <= '0;
      r_gap       <= '0;
      r_done      <= 1'b0;
      r_short     <= 1'b0;
      r_remainder <= '0;
      r_fault     <= 1'b0;
    end else begin
      if (r_state == ST_SELECT) r_sel10 <= w_pick10;

      if (r_state == ST_EJECT && !w_req) begin
        r_eject_10 <= r_sel10;
        r_eject_5  <= !r_sel10;
      end else if (w_ack || w_timeout) begin
        r_eject_10 <= 1'b0;
        r_eject_5  <= 1'b0;
      end

      if (r_state == ST_EJECT && w_req) r_wait <= r_wait + 1'b1;
      else                              r_wait <= '0;

      if (r_state == ST_GAP && !w_gap_end) r_gap <= r_gap + 1'b1;
      else                                 r_gap <= '0;

      if (w_timeout) r_fault <= 1'b1;

      r_done <= (r_state == ST_FINISH);
      if (r_state == ST_FINISH) begin
        r_remainder <= r_rem;
        r_short     <= (r_rem != '0);
      end
    end
  end

  // Subtraction only follows a SELECT that proved r_rem covers the coin.
  always_ff @(posedge clk) begin
    if (w_accept)   r_rem <= change_amt;
    else if (w_ack) r_rem <= r_rem - (r_eject_10 ? C10 : C5);
  end

  assign eject_5   = r_eject_5;
  assign eject_10  = r_eject_10;
  assign done      = r_done;
  assign short     = r_short;
  assign remainder = r_remainder;
  assign fault     = r_fault;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed testbench for change_dispenser with default parameters; tube
// inventory scenarios run only when CHANGE_INVENTORY_EN is defined.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic       change_valid;
  logic [7:0] change_amt;
  logic       eject_ack;
  logic       refill_5;
  logic       refill_10;
  logic       ready;
  logic       eject_5;
  logic       eject_10;
  logic       done;
  logic       short;
  logic [7:0] remainder;
  logic       fault;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] coin_sig;
  int          coin_n;
  int          coin_edge[$];
  int          acc_edge;
  int          done_edge;
  int          fault_edge;
  bit          got_done;
  logic [7:0]  got_rem;
  logic        got_short;
  logic        got_fault;
  logic        done_ready;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  change_dispenser dut (
    .clk          (clk),
    .rst          (rst),
    .change_valid (change_valid),
    .change_amt   (change_amt),
    .eject_ack    (eject_ack),
    .refill_5     (refill_5),
    .refill_10    (refill_10),
    .ready        (ready),
    .eject_5      (eject_5),
    .eject_10     (eject_10),
    .done         (done),
    .short        (short),
    .remainder    (remainder),
    .fault        (fault)
  );

  // Drives one payout and records coins (hex nibble A=10, 5=5), edges and results.
  // ack_dly = cycles after request rise at which ack is sampled; 0 = never ack.
  task automatic payout(input logic [7:0] amt, input int ack_dly, input int budget,
                        input bit poke, input bit refill_on_ack);
    int age;
    bit prev_req;
    bit poked;
    coin_sig = '0; coin_n = 0; coin_edge.delete();
    got_done = 0; got_rem = 'x; got_short = 1'bx; got_fault = 1'bx; done_ready = 1'bx;
    done_edge = -1; fault_edge = -1;
    @(negedge clk);
    change_valid = 1'b1; change_amt = amt;
    @(negedge clk);
    acc_edge = cyc;
    change_valid = 1'b0;
    age = 0; prev_req = 0; poked = 0;
    for (int i = 0; i < budget; i++) begin
      change_valid = 1'b0; refill_10 = 1'b0;
      if (fault && fault_edge < 0) fault_edge = cyc;
      if (done) begin
        got_done = 1; got_rem = remainder; got_short = short; got_fault = fault;
        done_ready = ready; done_edge = cyc;
        break;
      end
      if (eject_5 || eject_10) begin
        if (age == 0) begin
          coin_sig = (coin_sig << 4) | (eject_10 ? 64'hA : 64'h5);
          coin_n++;
          coin_edge.push_back(cyc);
        end
        age++;
        eject_ack = (ack_dly > 0 && age == ack_dly);
        refill_10 = refill_on_ack && eject_ack;
      end else begin
        if (prev_req && poke && !poked) begin
          change_valid = 1'b1; change_amt = 8'd50; poked = 1;
        end
        age = 0; eject_ack = 1'b0;
      end
      prev_req = eject_5 || eject_10;
      @(negedge clk);
    end
    change_valid = 1'b0; eject_ack = 1'b0; refill_10 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; change_valid = 1'b0; change_amt = '0; eject_ack = 1'b0;
    refill_5 = 1'b0; refill_10 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ready, eject_5, eject_10, done, short, fault, remainder} !== {1'b1, 5'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want %b",
               {ready, eject_5, eject_10, done, short, fault, remainder}, {1'b1, 5'b0, 8'h00});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b, want 1", ready); end
  endtask

  task automatic test_pay25();
    payout(8'd25, 3, 100, 0, 0);
    checks++;
    if (got_done !== 1'b1) begin errors++; $display("FAIL pay25_done: got %0b, want 1", got_done); end
    checks++;
    if (coin_sig !== 64'hAA5) begin errors++; $display("FAIL pay25_coins: got %h, want aa5", coin_sig); end
    checks++;
    if (coin_n == 3 && {coin_edge[0] - acc_edge, coin_edge[1] - acc_edge, coin_edge[2] - acc_edge} !== {32'd2, 32'd11, 32'd20}) begin
      errors++;
      $display("FAIL pay25_eject_edges: got %0d %0d %0d, want 2 11 20",
               coin_edge[0] - acc_edge, coin_edge[1] - acc_edge, coin_edge[2] - acc_edge);
    end
    checks++;
    if (done_edge - acc_edge !== 29) begin errors++; $display("FAIL pay25_done_edge: got %0d, want 29", done_edge - acc_edge); end
    checks++;
    if ({got_rem, got_short} !== {8'd0, 1'b0}) begin
      errors++; $display("FAIL pay25_result: got rem %0d short %b, want rem 0 short 0", got_rem, got_short);
    end
  endtask

  task automatic test_pay17();
    payout(8'd17, 3, 100, 0, 0);
    checks++;
    if (coin_sig !== 64'hA5) begin errors++; $display("FAIL pay17_coins: got %h, want a5", coin_sig); end
    checks++;
    if ({got_done, got_rem, got_short} !== {1'b1, 8'd2, 1'b1}) begin
      errors++; $display("FAIL pay17_result: got done %b rem %0d short %b, want done 1 rem 2 short 1",
                         got_done, got_rem, got_short);
    end
    checks++;
    if (done_edge - acc_edge !== 20) begin errors++; $display("FAIL pay17_done_edge: got %0d, want 20", done_edge - acc_edge); end
  endtask

  task automatic test_nothing_payable();
    payout(8'd0, 3, 20, 0, 0);
    checks++;
    if ({got_done, coin_n[7:0], got_rem, got_short} !== {1'b1, 8'd0, 8'd0, 1'b0}) begin
      errors++; $display("FAIL zero_result: got done %b coins %0d rem %0d short %b, want 1 0 0 0",
                         got_done, coin_n, got_rem, got_short);
    end
    checks++;
    if (done_edge - acc_edge !== 2) begin errors++; $display("FAIL zero_done_edge: got %0d, want 2", done_edge - acc_edge); end
    checks++;
    if (done_ready !== 1'b0) begin errors++; $display("FAIL ready_during_done: got %b, want 0", done_ready); end
    @(negedge clk);
    checks++;
    if ({ready, done} !== 2'b10) begin errors++; $display("FAIL ready_after_done: got ready %b done %b, want 1 0", ready, done); end
    payout(8'd3, 3, 20, 0, 0);
    checks++;
    if ({got_done, coin_n[7:0], got_rem, got_short} !== {1'b1, 8'd0, 8'd3, 1'b1}) begin
      errors++; $display("FAIL residue3_result: got done %b coins %0d rem %0d short %b, want 1 0 3 1",
                         got_done, coin_n, got_rem, got_short);
    end
  endtask

  task automatic test_back_to_back();
    payout(8'd5, 1, 50, 0, 0);
    checks++;
    if ({coin_sig[7:0], got_rem, got_short} !== {8'h05, 8'd0, 1'b0}) begin
      errors++; $display("FAIL b2b_first: got coins %h rem %0d short %b, want 05 0 0", coin_sig[7:0], got_rem, got_short);
    end
    payout(8'd10, 1, 50, 0, 0);
    checks++;
    if ({coin_sig[7:0], got_rem, got_short} !== {8'h0A, 8'd0, 1'b0}) begin
      errors++; $display("FAIL b2b_second: got coins %h rem %0d short %b, want 0a 0 0", coin_sig[7:0], got_rem, got_short);
    end
  endtask

  task automatic test_gap_ignore();
    payout(8'd15, 3, 100, 1, 0);
    checks++;
    if ({got_done, coin_sig[15:0], got_rem} !== {1'b1, 16'h00A5, 8'd0}) begin
      errors++; $display("FAIL gap_valid_ignored: got done %b coins %h rem %0d, want 1 a5 0",
                         got_done, coin_sig[15:0], got_rem);
    end
    repeat (10) @(negedge clk);
    checks++;
    if ({ready, eject_5, eject_10} !== 3'b100) begin
      errors++; $display("FAIL gap_idle_after: got %b, want 100", {ready, eject_5, eject_10});
    end
  endtask

  task automatic test_timeout();
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL fault_before_timeout: got %b, want 0", fault); end
    payout(8'd10, 0, 400, 0, 0);
    checks++;
    if ({got_done, coin_sig[7:0], got_rem, got_short, got_fault} !== {1'b1, 8'h0A, 8'd10, 1'b1, 1'b1}) begin
      errors++; $display("FAIL timeout_result: got done %b coins %h rem %0d short %b fault %b, want 1 0a 10 1 1",
                         got_done, coin_sig[7:0], got_rem, got_short, got_fault);
    end
    checks++;
    if ({fault_edge - acc_edge, done_edge - acc_edge} !== {32'd257, 32'd258}) begin
      errors++; $display("FAIL timeout_edges: got fault %0d done %0d, want 257 258",
                         fault_edge - acc_edge, done_edge - acc_edge);
    end
    payout(8'd5, 3, 50, 0, 0);
    checks++;
    if ({got_done, coin_sig[7:0], got_rem, got_short, got_fault} !== {1'b1, 8'h05, 8'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL after_fault_payout: got done %b coins %h rem %0d short %b fault %b, want 1 05 0 0 1",
                         got_done, coin_sig[7:0], got_rem, got_short, got_fault);
    end
  endtask

`ifdef CHANGE_INVENTORY_EN
  task automatic test_inventory();
    // Earlier payouts consumed five coins from each tube (16 -> 11).
    payout(8'd110, 1, 200, 0, 0);
    checks++;
    if ({coin_n[7:0], got_rem, 32'(dut.u_tube10.o_count)} !== {8'd11, 8'd0, 32'd0}) begin
      errors++; $display("FAIL inv_drain10: got coins %0d rem %0d cnt10 %0d, want 11 0 0",
                         coin_n, got_rem, dut.u_tube10.o_count);
    end
    payout(8'd20, 1, 100, 0, 0);
    checks++;
    if ({coin_sig[15:0], got_rem, 32'(dut.u_tube5.o_count)} !== {16'h5555, 8'd0, 32'd7}) begin
      errors++; $display("FAIL inv_fives_only: got coins %h rem %0d cnt5 %0d, want 5555 0 7",
                         coin_sig[15:0], got_rem, dut.u_tube5.o_count);
    end
    @(negedge clk); refill_10 = 1'b1;
    @(negedge clk); refill_10 = 1'b0;
    payout(8'd10, 3, 50, 0, 1);
    checks++;
    if ({coin_sig[7:0], 32'(dut.u_tube10.o_count)} !== {8'h0A, 32'd1}) begin
      errors++; $display("FAIL inv_refill_ack_same: got coins %h cnt10 %0d, want 0a 1",
                         coin_sig[7:0], dut.u_tube10.o_count);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); refill_5 = 1'b1;
    end
    @(negedge clk); refill_5 = 1'b0;
    checks++;
    if (32'(dut.u_tube5.o_count) !== 32'd31) begin
      errors++; $display("FAIL inv_refill_saturate: got %0d, want 31", dut.u_tube5.o_count);
    end
  endtask
`endif

  task automatic test_reset_mid();
    @(negedge clk);
    change_valid = 1'b1; change_amt = 8'd10;
    @(negedge clk);
    change_valid = 1'b0;
    for (int i = 0; i < 10 && eject_10 !== 1'b1; i++) @(negedge clk);
    checks++;
    if (eject_10 !== 1'b1) begin errors++; $display("FAIL reset_mid_request: got %b, want 1", eject_10); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ready, eject_5, eject_10, done, short, fault, remainder} !== {1'b1, 5'b0, 8'h00}) begin
      errors++; $display("FAIL reset_mid_outputs: got %b, want %b",
                         {ready, eject_5, eject_10, done, short, fault, remainder}, {1'b1, 5'b0, 8'h00});
    end
`ifdef CHANGE_INVENTORY_EN
    checks++;
    if ({32'(dut.u_tube5.o_count), 32'(dut.u_tube10.o_count)} !== {32'd16, 32'd16}) begin
      errors++; $display("FAIL reset_mid_counts: got %0d %0d, want 16 16", dut.u_tube5.o_count, dut.u_tube10.o_count);
    end
`endif
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ready, eject_10, done} !== 3'b100) begin
      errors++; $display("FAIL reset_mid_after: got %b, want 100", {ready, eject_10, done});
    end
  endtask

  initial begin
    test_reset();
    test_pay25();
    test_pay17();
    test_nothing_payable();
    test_back_to_back();
    test_gap_ignore();
    test_timeout();
`ifdef CHANGE_INVENTORY_EN
    test_inventory();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
